// File: rtl/spi_slave.sv
// SPI responder: oversamples SCK/CS/MOSI on clk, captures WIDTH bits LSB first
// while shifting tx_data out on MISO, in any CKP/CPH mode.
module spi_slave #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             CKP,
  input  logic             CPH,
  input  logic             SCK,
  input  logic             CS,
  input  logic             MOSI,
  input  logic [WIDTH-1:0] tx_data,
  output logic             MISO,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t state_reg, state_next;

  logic [SYNC_STAGES-1:0] sck_sync_reg, cs_sync_reg, mosi_sync_reg;
  logic [SYNC_STAGES-1:0] sck_sync_next, cs_sync_next, mosi_sync_next;
  logic                   sck_hist_reg, cs_hist_reg;

  logic [WIDTH-1:0] tx_hold_reg, rx_shift_reg, rx_data_reg;
  logic [CW-1:0]    bit_cnt_reg;
  logic             miso_reg, rx_valid_reg, commit_reg;

  logic sck_s, cs_s, mosi_s;
  logic sck_edge, lead_edge, trail_edge, sample_edge, shift_edge;
  logic cs_fall, cs_rise;
  logic start, take, drive, leave;
  logic [IW-1:0] bit_idx;

  // Synchronizer chains: stage 0 takes the pin, each later stage the one before.
  assign sck_sync_next[0]  = SCK;
  assign cs_sync_next[0]   = CS;
  assign mosi_sync_next[0] = MOSI;
  generate
    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
      assign sck_sync_next[gi]  = sck_sync_reg[gi-1];
      assign cs_sync_next[gi]   = cs_sync_reg[gi-1];
      assign mosi_sync_next[gi] = mosi_sync_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      sck_sync_reg  <= {SYNC_STAGES{CKP}};
      cs_sync_reg   <= {SYNC_STAGES{1'b1}};
      mosi_sync_reg <= '0;
      sck_hist_reg  <= CKP;
      cs_hist_reg   <= 1'b1;
    end else begin
      sck_sync_reg  <= sck_sync_next;
      cs_sync_reg   <= cs_sync_next;
      mosi_sync_reg <= mosi_sync_next;
      sck_hist_reg  <= sck_s;
      cs_hist_reg   <= cs_s;
    end
  end

  assign sck_s  = sck_sync_reg[SYNC_STAGES-1];
  assign cs_s   = cs_sync_reg[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];

  // Leading edge moves SCK away from its idle level CKP; trailing returns to it.
  assign sck_edge    = sck_s ^ sck_hist_reg;
  assign lead_edge   = sck_edge & (sck_s ^ CKP);
  assign trail_edge  = sck_edge & ~(sck_s ^ CKP);
  assign sample_edge = CPH ? trail_edge : lead_edge;
  assign shift_edge  = CPH ? lead_edge : trail_edge;
  assign cs_fall     = cs_hist_reg & ~cs_s;
  assign cs_rise     = ~cs_hist_reg & cs_s;
  assign bit_idx     = bit_cnt_reg[IW-1:0];

  always_ff @(posedge clk) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    take       = 1'b0;
    drive      = 1'b0;
    leave      = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (cs_fall) begin
          start      = 1'b1;
          state_next = XFER;
        end
      end
      XFER: begin
        // A CS rise outranks any edge seen in the same cycle.
        if (cs_rise) begin
          leave      = 1'b1;
          state_next = IDLE;
        end else if (sample_edge) begin
          take = 1'b1;
          if (bit_cnt_reg == CW'(WIDTH - 1)) state_next = DONE;
        end else if (shift_edge) begin
          drive = 1'b1;
        end
      end
      DONE: begin
        if (cs_rise) begin
          leave      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_hold_reg  <= '0;
      rx_shift_reg <= '0;
      rx_data_reg  <= '0;
      bit_cnt_reg  <= '0;
      miso_reg     <= 1'b0;
      rx_valid_reg <= 1'b0;
      commit_reg   <= 1'b0;
    end else begin
      commit_reg   <= take && (bit_cnt_reg == CW'(WIDTH - 1));
      rx_valid_reg <= commit_reg;
      if (commit_reg) rx_data_reg <= rx_shift_reg;

      if (start) begin
        tx_hold_reg <= tx_data;
        bit_cnt_reg <= '0;
        miso_reg    <= CPH ? 1'b0 : tx_data[0];
      end else if (leave) begin
        bit_cnt_reg <= '0;
        miso_reg    <= 1'b0;
      end else if (take) begin
        rx_shift_reg[bit_idx] <= mosi_s;
        bit_cnt_reg           <= bit_cnt_reg + 1'b1;
      end else if (drive) begin
        // In both phases the bit due next equals the number of samples taken.
        miso_reg <= tx_hold_reg[bit_idx];
      end
    end
  end

  assign MISO     = miso_reg;
  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;
  assign busy     = (state_reg != IDLE);

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder (slave) for the other end of the team's SPI master link.
- Runs on the system clock. Oversamples SCK, CS and MOSI through synchronizers.
- Shifts a 16-bit word out on MISO while capturing a 16-bit word from MOSI.
- Supports all four CKP/CPH modes. Presents each completed received word to local logic with a one-cycle valid strobe.

Parameters:
- WIDTH, 16, frame length in bits. Also sets the width of tx_data and rx_data.
- SYNC_STAGES, 2, flip-flop synchronizer depth on the SCK, CS and MOSI inputs.

Ports:
- clk  input  1  system clock. All logic is on its rising edge.
- rst  input  1  synchronous, active-low reset.
- CKP  input  1  clock polarity: 0 = SCK idles low, 1 = SCK idles high. Static during a frame.
- CPH  input  1  clock phase: 0 = sample on leading edge, 1 = sample on trailing edge. Static during a frame.
- SCK  input  1  serial clock from the master.
- CS  input  1  chip select, active low.
- MOSI  input  1  serial data from the master.
- tx_data  input  WIDTH  word to transmit. Captured when CS falls.
- MISO  output  1  serial data to the master.
- rx_data  output  WIDTH  last complete received word.
- rx_valid  output  1  one-cycle strobe: rx_data was just updated.
- busy  output  1  high while a frame is in progress (states XFER and DONE).

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE; bit counter=0; shift registers=0.
  - MISO=0, rx_data=0, rx_valid=0, busy=0.
  - Synchronizers are loaded with the idle values: CS=1, SCK=CKP, MOSI=0.
  - Reset mid-frame aborts the frame silently. After reset release the block waits for a new CS fall.
- Input conditioning:
  - SCK, CS and MOSI each pass through SYNC_STAGES flops, plus one history flop for edge detection.
  - Leading edge = SCK transition away from its idle level (CKP). Trailing edge = transition back to CKP.
  - Sample edge = leading if CPH=0, trailing if CPH=1. Shift edge = the other one.
  - SCK high and low phases must each last at least 3 clk cycles. The master's clk/8 SCK satisfies this.
- Bit order: LSB first on both MOSI and MISO, matching the master (bit 0 first, bit WIDTH-1 last).
- States:
  - IDLE:
    - MISO=0; SCK edges are ignored.
    - On a synchronized CS fall: load tx_data into the tx shift register, clear the bit counter, go to XFER.
    - If CPH=0, MISO=tx_data[0] from the next cycle, i.e. before the first leading edge.
  - XFER:
    - On each sample edge: rx shift register bit[counter] <= synchronized MOSI, then counter +1.
    - On each shift edge: if CPH=0, MISO <- next tx bit. If CPH=1, MISO <- tx bit[counter], where the first shift edge presents bit 0.
    - MISO changes exactly 1 clk after the edge is detected.
    - When the sample that makes counter reach WIDTH is taken, go to DONE.
  - DONE:
    - Next cycle: rx_data <= rx shift register and rx_valid=1 for exactly one cycle.
    - Further SCK edges are ignored and MISO is held at its last value.
    - On CS rise: go to IDLE, MISO=0.
- Boundary cases:
  - CS rises in XFER before WIDTH samples (abort): go to IDLE; rx_data keeps its old value; no rx_valid; counter cleared.
  - CS rise and a sample edge detected in the same cycle: CS wins; the bit is discarded.
  - CS low for more than WIDTH sample edges: extra edges are ignored. A new frame requires CS high for at least 1 synchronized cycle, then low again.
  - The counter never wraps past WIDTH.
  - Changing tx_data during a frame has no effect until the next CS fall.
- Output driving: MISO is always driven, never tri-stated. The 0 driven while CS is high is a defined level, not high-Z.
- Latency: rx_valid asserts SYNC_STAGES+2 clk cycles after the final sample edge appears on the SCK pin.

Test Plan:
- Mode 0 (CKP=0, CPH=0), tx_data=16'hA5C3, master sends 16'h0407 at SCK=clk/8 → rx_data=16'h0407 with one rx_valid pulse; master captures 16'hA5C3 LSB first; busy falls after CS rises.
- Repeat the 16'h0407 / 16'hA5C3 exchange in modes 1, 2 and 3 (CKP/CPH = 0/1, 1/0, 1/1) → identical data in both directions; MISO changes only 1 clk after shift edges.
- Abort: CS raised after 7 SCK periods with tx_data=16'hFFFF → no rx_valid; rx_data keeps the prior 16'h0407; MISO=0 within SYNC_STAGES+2 cycles; the next full frame of 16'h1234 is received correctly.
- Extra clocks: 20 SCK periods during one CS-low window sending 16'hBEEF → exactly one rx_valid, rx_data=16'hBEEF; edges 17–20 have no effect.
- Reset at bit 9 of a frame → all outputs return to 0 on the next clk. A subsequent frame after CS toggles high then low transfers 16'h0F0F correctly.
- Back-to-back frames 16'h0001 then 16'h8000 with CS high for 4 clk between them → two rx_valid pulses with the correct values; tx_data reloaded at each CS fall.
